preif_stage: RTL and testbench

- Pre-IF fetch unit for the 5-stage LoongArch pipeline.
- Sits between the SRAM-like instruction bus and the IF stage.
- Owns the fetch PC and issues one outstanding instruction request at a time.
- Absorbs branch, exception and ertn redirects arriving at any point in a transaction, discarding stale responses.
- Delivers {adef, inst, pc} to IF through a one-entry buffer with a valid/allowin handshake.

---
 rtl/preif_stage_pkg.sv | 38 +++
 rtl/pfs_redirect_buf.sv | 60 ++++++
 rtl/preif_stage.sv | 153 +++++++++++++++
 tb/tb_preif_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/preif_stage_pkg.sv
// Shared definitions for the pre-IF fetch stage: bus widths, field offsets,
// state encodings and the default reset PC.
package preif_stage_pkg;

    localparam int PFS_TO_FS_BUS_WD = 65;
    localparam int BR_BUS_WD        = 33;

    // pfs_to_fs_bus = {adef, inst[31:0], pc[31:0]}
    localparam int FS_PC_LSB   = 0;
    localparam int FS_INST_LSB = 32;
    localparam int FS_ADEF_BIT = 64;

    // br_bus = {br_taken, br_target[31:0]}
    localparam int BR_TARGET_LSB = 0;
    localparam int BR_TAKEN_BIT  = 32;

    localparam logic [1:0] PFS_REQ  = 2'd0;
    localparam logic [1:0] PFS_WAIT = 2'd1;
    localparam logic [1:0] PFS_HOLD = 2'd2;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h1c00_0000;

    typedef struct packed {
        logic        adef;
        logic [31:0] inst;
        logic [31:0] pc;
    } pfs_to_fs_t;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } br_t;

    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pfs_redirect_buf.sv
// Redirect bookkeeping for the pre-IF stage: merges the redirect sources of
// the current cycle by priority and remembers a redirect that arrived while a
// bus transaction was in flight (pending target + discard flag).
module pfs_redirect_buf
    import preif_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BR_BUS_WD-1:0] br_bus,
    input  logic                 wb_exc,
    input  logic                 wb_ertn,
    input  logic [31:0]          exc_entry,
    input  logic [31:0]          exc_retaddr,
    input  logic                 record,      // redirect must wait for the in-flight response
    input  logic                 consume,     // in-flight response has returned this cycle
    output logic                 redir_now,
    output logic [31:0]          sel_target,  // target to load into pc when redirecting/dropping
    output logic                 discard
);

    br_t         br;
    logic        cur_wb;
    logic [31:0] cur_target;
    logic        take_cur;
    logic        pend_valid;
    logic        pend_wb;
    logic [31:0] pend_target;

    // A branch seen after a WB flush is stale and must not replace the WB target.
    always_comb begin
        br         = br_t'(br_bus);
        cur_wb     = wb_exc | wb_ertn;
        redir_now  = cur_wb | br.taken;
        cur_target = wb_exc  ? exc_entry   :
                     wb_ertn ? exc_retaddr : br.target;
        take_cur   = redir_now && (!pend_valid || cur_wb || !pend_wb);
        sel_target = take_cur ? cur_target : pend_target;
    end

    // Pending redirect and discard flag; cleared when the dropped response returns.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid  <= 1'b0;
            pend_wb     <= 1'b0;
            pend_target <= 32'h0;
            discard     <= 1'b0;
        end else if (consume) begin
            pend_valid <= 1'b0;
            discard    <= 1'b0;
        end else if (record) begin
            pend_valid <= 1'b1;
            discard    <= 1'b1;
            if (take_cur) begin
                pend_target <= cur_target;
                pend_wb     <= cur_wb;
            end
        end
    end

endmodule

// File: rtl/preif_stage.sv
// Pre-IF fetch stage: owns the fetch PC, issues one instruction request at a
// time on the SRAM-like bus and hands {adef, inst, pc} to IF via a one-entry
// buffer. Optional performance counters are enabled with PFS_PERF_CNT_EN.
module preif_stage
    import preif_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        fs_allowin,
    output logic                        pfs_to_fs_valid,
    output logic [PFS_TO_FS_BUS_WD-1:0] pfs_to_fs_bus,
    input  logic [BR_BUS_WD-1:0]        br_bus,
    input  logic                        wb_exc,
    input  logic                        wb_ertn,
    input  logic [31:0]                 exc_entry,
    input  logic [31:0]                 exc_retaddr,
    output logic                        inst_sram_req,
    output logic                        inst_sram_wr,
    output logic [1:0]                  inst_sram_size,
    output logic [3:0]                  inst_sram_wstrb,
    output logic [31:0]                 inst_sram_addr,
    output logic [31:0]                 inst_sram_wdata,
    input  logic                        inst_sram_addr_ok,
    input  logic                        inst_sram_data_ok,
    input  logic [31:0]                 inst_sram_rdata,
    output logic [31:0]                 perf_fetch_cnt,
    output logic [31:0]                 perf_discard_cnt
);

    logic [1:0]  state;
    logic [31:0] pc;
    logic        run;        // low for the cycle right after reset so req starts low
    logic        fs_valid;
    pfs_to_fs_t  fs_buf;

    logic        bus_req;
    logic        resp_in;
    logic        resp_drop;
    logic        fetch_load;
    logic        record;
    logic        redir_now;
    logic [31:0] sel_target;
    logic        discard;

    pfs_redirect_buf u_redir (
        .clk         (clk),
        .reset       (reset),
        .br_bus      (br_bus),
        .wb_exc      (wb_exc),
        .wb_ertn     (wb_ertn),
        .exc_entry   (exc_entry),
        .exc_retaddr (exc_retaddr),
        .record      (record),
        .consume     (resp_in),
        .redir_now   (redir_now),
        .sel_target  (sel_target),
        .discard     (discard)
    );

    // Bus request and response classification; a redirect with data_ok drops that data.
    always_comb begin
        bus_req    = run && (state == PFS_REQ) && !pc_misaligned(pc);
        resp_in    = (state == PFS_WAIT) && inst_sram_data_ok;
        resp_drop  = resp_in && (discard || redir_now);
        fetch_load = resp_in && !(discard || redir_now);
        record     = redir_now && (bus_req || ((state == PFS_WAIT) && !inst_sram_data_ok));
    end

    assign inst_sram_req   = bus_req;
    assign inst_sram_addr  = pc;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'h0;
    assign inst_sram_wdata = 32'h0;

    assign pfs_to_fs_valid = fs_valid;
    assign pfs_to_fs_bus   = fs_buf;

    // Fetch FSM: REQ issues (or raises ADEF), WAIT collects, HOLD hands to IF.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= PFS_REQ;
            pc       <= RESET_PC;
            run      <= 1'b0;
            fs_valid <= 1'b0;
            fs_buf   <= '0;
        end else begin
            run <= 1'b1;
            case (state)
                PFS_REQ: begin
                    if (!bus_req) begin
                        if (redir_now) begin
                            pc <= sel_target;
                        end else if (pc_misaligned(pc)) begin
                            fs_valid <= 1'b1;
                            fs_buf   <= '{adef: 1'b1, inst: 32'h0, pc: pc};
                            state    <= PFS_HOLD;
                        end
                    end else if (inst_sram_addr_ok) begin
                        state <= PFS_WAIT;
                    end
                end
                PFS_WAIT: begin
                    if (resp_drop) begin
                        pc    <= sel_target;
                        state <= PFS_REQ;
                    end else if (fetch_load) begin
                        fs_valid <= 1'b1;
                        fs_buf   <= '{adef: 1'b0, inst: inst_sram_rdata, pc: pc};
                        state    <= PFS_HOLD;
                    end
                end
                PFS_HOLD: begin
                    if (redir_now) begin
                        fs_valid <= 1'b0;
                        pc       <= sel_target;
                        state    <= PFS_REQ;
                    end else if (fs_allowin) begin
                        fs_valid <= 1'b0;
                        pc       <= pc + 32'd4;
                        state    <= PFS_REQ;
                    end
                end
                default: state <= PFS_REQ;
            endcase
        end
    end

`ifdef PFS_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] discard_cnt;

    // Count buffer loads from the bus and dropped responses; both wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt   <= 32'h0;
            discard_cnt <= 32'h0;
        end else begin
            if (fetch_load) fetch_cnt   <= fetch_cnt + 32'd1;
            if (resp_drop)  discard_cnt <= discard_cnt + 32'd1;
        end
    end

    assign perf_fetch_cnt   = fetch_cnt;
    assign perf_discard_cnt = discard_cnt;
`else
    assign perf_fetch_cnt   = 32'h0;
    assign perf_discard_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_preif_stage.sv
// Directed bench for preif_stage: table-driven fetches plus hand sequences
// for redirects, ADEF, stalls and mid-transaction reset.
module tb_preif_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        fs_allowin;
    logic        pfs_to_fs_valid;
    logic [64:0] pfs_to_fs_bus;
    logic [32:0] br_bus;
    logic        wb_exc;
    logic        wb_ertn;
    logic [31:0] exc_entry;
    logic [31:0] exc_retaddr;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_discard_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    preif_stage dut (
        .clk               (clk),
        .reset             (reset),
        .fs_allowin        (fs_allowin),
        .pfs_to_fs_valid   (pfs_to_fs_valid),
        .pfs_to_fs_bus     (pfs_to_fs_bus),
        .br_bus            (br_bus),
        .wb_exc            (wb_exc),
        .wb_ertn           (wb_ertn),
        .exc_entry         (exc_entry),
        .exc_retaddr       (exc_retaddr),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .perf_fetch_cnt    (perf_fetch_cnt),
        .perf_discard_cnt  (perf_discard_cnt)
    );

    typedef struct {
        int          addr_lat;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [64:0] exp_bus;
    } vec_t;

    vec_t vecs[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [64:0] got, input logic [64:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Bounded wait for a request, then check its address.
    task automatic wait_req(input logic [31:0] exp_addr);
        int i = 0;
        while (!inst_sram_req && i < 10) begin
            tick();
            i++;
        end
        chk("req_seen", 65'(inst_sram_req), 65'(1'b1));
        chk("req_addr", 65'(inst_sram_addr), 65'(exp_addr));
    endtask

    // Withhold addr_ok for lat cycles (req/addr must hold), then accept.
    task automatic addr_phase(input int lat, input logic [31:0] exp_addr);
        for (int c = 0; c < lat; c++) begin
            tick();
            chk("req_hold", 65'(inst_sram_req), 65'(1'b1));
            chk("addr_hold", 65'(inst_sram_addr), 65'(exp_addr));
        end
        inst_sram_addr_ok = 1'b1;
        tick();
        inst_sram_addr_ok = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data);
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = data;
        tick();
        inst_sram_data_ok = 1'b0;
    endtask

    task automatic consume();
        fs_allowin = 1'b1;
        tick();
        fs_allowin = 1'b0;
        chk("consumed_valid", 65'(pfs_to_fs_valid), 65'(1'b0));
    endtask

    initial begin
        reset             = 1'b1;
        fs_allowin        = 1'b0;
        br_bus            = '0;
        wb_exc            = 1'b0;
        wb_ertn           = 1'b0;
        exc_entry         = 32'h0;
        exc_retaddr       = 32'h0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'h0;

        vecs[0] = '{addr_lat: 0, rdata: 32'h0280_0401, exp_addr: 32'h1c00_0000,
                    exp_bus: {1'b0, 32'h0280_0401, 32'h1c00_0000}};
        vecs[1] = '{addr_lat: 2, rdata: 32'h1500_0024, exp_addr: 32'h1c00_0004,
                    exp_bus: {1'b0, 32'h1500_0024, 32'h1c00_0004}};

        // reset state
        repeat (3) tick();
        chk("rst_req", 65'(inst_sram_req), 65'(1'b0));
        chk("rst_valid", 65'(pfs_to_fs_valid), 65'(1'b0));
        chk("rst_addr", 65'(inst_sram_addr), 65'(32'h1c00_0000));
        chk("rst_perf_fetch", 65'(perf_fetch_cnt), 65'(32'h0));
        chk("rst_perf_discard", 65'(perf_discard_cnt), 65'(32'h0));
        chk("const_wr", 65'(inst_sram_wr), 65'(1'b0));
        chk("const_size", 65'(inst_sram_size), 65'(2'b10));
        chk("const_wstrb", 65'(inst_sram_wstrb), 65'(4'h0));
        chk("const_wdata", 65'(inst_sram_wdata), 65'(32'h0));
        reset = 1'b0;

        // sequential fetches
        foreach (vecs[k]) begin
            wait_req(vecs[k].exp_addr);
            addr_phase(vecs[k].addr_lat, vecs[k].exp_addr);
            respond(vecs[k].rdata);
            chk("tbl_valid", 65'(pfs_to_fs_valid), 65'(1'b1));
            chk("tbl_bus", pfs_to_fs_bus, vecs[k].exp_bus);
            chk("tbl_no_req", 65'(inst_sram_req), 65'(1'b0));
            consume();
        end

        // branch in WAIT: response for 0x1c000008 dropped
        wait_req(32'h1c00_0008);
        addr_phase(0, 32'h1c00_0008);
        br_bus = {1'b1, 32'h1c00_0100};
        tick();
        br_bus = '0;
        respond(32'hdead_beef);
        chk("br_drop_valid", 65'(pfs_to_fs_valid), 65'(1'b0));
`ifdef PFS_PERF_CNT_EN
        chk("br_perf_discard", 65'(perf_discard_cnt), 65'(32'd1));
`else
        chk("br_perf_discard", 65'(perf_discard_cnt), 65'(32'd0));
`endif
        chk("br_req_now", 65'(inst_sram_req), 65'(1'b1));
        wait_req(32'h1c00_0100);
        addr_phase(1, 32'h1c00_0100);
        respond(32'h0000_0100);
        chk("br_tgt_bus", pfs_to_fs_bus, {1'b0, 32'h0000_0100, 32'h1c00_0100});
        consume();

        // wb_exc beats br_taken in HOLD
        wait_req(32'h1c00_0104);
        addr_phase(0, 32'h1c00_0104);
        respond(32'h0000_0104);
        chk("exc_hold_valid", 65'(pfs_to_fs_valid), 65'(1'b1));
        wb_exc    = 1'b1;
        exc_entry = 32'h1c00_8000;
        br_bus    = {1'b1, 32'h1c00_0200};
        tick();
        wb_exc = 1'b0;
        br_bus = '0;
        chk("exc_valid", 65'(pfs_to_fs_valid), 65'(1'b0));
        chk("exc_req_now", 65'(inst_sram_req), 65'(1'b1));
        chk("exc_addr", 65'(inst_sram_addr), 65'(32'h1c00_8000));

        // HOLD stall, redirect in cycle 3 even with fs_allowin=1
        addr_phase(0, 32'h1c00_8000);
        respond(32'h0000_8000);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("stall_valid", 65'(pfs_to_fs_valid), 65'(1'b1));
            chk("stall_bus", pfs_to_fs_bus, {1'b0, 32'h0000_8000, 32'h1c00_8000});
            chk("stall_no_req", 65'(inst_sram_req), 65'(1'b0));
        end
        fs_allowin = 1'b1;
        br_bus     = {1'b1, 32'h1c00_0300};
        tick();
        fs_allowin = 1'b0;
        br_bus     = '0;
        chk("stall_redir_valid", 65'(pfs_to_fs_valid), 65'(1'b0));
        chk("stall_redir_req", 65'(inst_sram_req), 65'(1'b1));
        chk("stall_redir_addr", 65'(inst_sram_addr), 65'(32'h1c00_0300));
        addr_phase(2, 32'h1c00_0300);
        respond(32'h0000_0300);
        chk("stall_tgt_bus", pfs_to_fs_bus, {1'b0, 32'h0000_0300, 32'h1c00_0300});
        consume();

        // redirect with data_ok to a misaligned target -> ADEF
        wait_req(32'h1c00_0304);
        addr_phase(0, 32'h1c00_0304);
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = 32'h1234_5678;
        br_bus            = {1'b1, 32'h1c00_0102};
        tick();
        inst_sram_data_ok = 1'b0;
        br_bus            = '0;
        chk("same_drop_valid", 65'(pfs_to_fs_valid), 65'(1'b0));
        chk("adef_no_req0", 65'(inst_sram_req), 65'(1'b0));
`ifdef PFS_PERF_CNT_EN
        chk("same_perf_discard", 65'(perf_discard_cnt), 65'(32'd2));
`else
        chk("same_perf_discard", 65'(perf_discard_cnt), 65'(32'd0));
`endif
        tick();
        chk("adef_valid", 65'(pfs_to_fs_valid), 65'(1'b1));
        chk("adef_bus", pfs_to_fs_bus, {1'b1, 32'h0, 32'h1c00_0102});
        chk("adef_no_req1", 65'(inst_sram_req), 65'(1'b0));
        tick();
        chk("adef_no_req2", 65'(inst_sram_req), 65'(1'b0));
        chk("adef_valid2", 65'(pfs_to_fs_valid), 65'(1'b1));
        br_bus = {1'b1, 32'h1c00_0400};
        tick();
        br_bus = '0;
        chk("adef_redir_valid", 65'(pfs_to_fs_valid), 65'(1'b0));

        // addr_ok withheld, wb_ertn during the wait
        wait_req(32'h1c00_0400);
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin
                wb_ertn     = 1'b1;
                exc_retaddr = 32'h1c00_0040;
            end
            tick();
            wb_ertn = 1'b0;
            chk("ertn_req_hold", 65'(inst_sram_req), 65'(1'b1));
            chk("ertn_addr_hold", 65'(inst_sram_addr), 65'(32'h1c00_0400));
        end
        addr_phase(0, 32'h1c00_0400);
        respond(32'h0bad_0bad);
        chk("ertn_drop_valid", 65'(pfs_to_fs_valid), 65'(1'b0));
`ifdef PFS_PERF_CNT_EN
        chk("ertn_perf_discard", 65'(perf_discard_cnt), 65'(32'd3));
`else
        chk("ertn_perf_discard", 65'(perf_discard_cnt), 65'(32'd0));
`endif
        wait_req(32'h1c00_0040);
        addr_phase(0, 32'h1c00_0040);
        respond(32'h0000_0040);
        chk("ertn_tgt_bus", pfs_to_fs_bus, {1'b0, 32'h0000_0040, 32'h1c00_0040});
        consume();
`ifdef PFS_PERF_CNT_EN
        chk("perf_fetch_total", 65'(perf_fetch_cnt), 65'(32'd7));
`else
        chk("perf_fetch_total", 65'(perf_fetch_cnt), 65'(32'd0));
`endif

        // reset in the middle of a transaction
        wait_req(32'h1c00_0044);
        addr_phase(0, 32'h1c00_0044);
        reset = 1'b1;
        tick();
        chk("mid_rst_req", 65'(inst_sram_req), 65'(1'b0));
        chk("mid_rst_valid", 65'(pfs_to_fs_valid), 65'(1'b0));
        chk("mid_rst_perf", 65'(perf_fetch_cnt), 65'(32'h0));
        reset = 1'b0;
        wait_req(32'h1c00_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
